// File: rtl/sram_lsu_pkg.sv
// Shared types and parameter checks for the core-to-SRAM load/store bridge.
package sram_lsu_pkg;

  localparam int RD_LATENCY_MAX = 4;

  typedef struct packed {
    logic valid;
    logic we;
    logic err;
  } resp_entry_t;

  typedef enum logic {
    ERR_ARMED = 1'b0,
    ERR_HELD  = 1'b1
  } err_state_e;

  function automatic bit params_legal(int data_width, int addr_width, int mem_words,
                                      int rd_latency);
    int offs;
    offs = $clog2(data_width / 8);
    return (data_width >= 8) && (data_width % 8 == 0) &&
           (mem_words >= 2) && ((mem_words & (mem_words - 1)) == 0) &&
           (addr_width >= $clog2(mem_words) + offs) &&
           (rd_latency >= 1) && (rd_latency <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/sram_lsu_resp_pipe.sv
// Fixed-depth shift register carrying response tags alongside the SRAM read latency.
module sram_lsu_resp_pipe
  import sram_lsu_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  resp_entry_t push_i,
  output resp_entry_t head_o
);

  resp_entry_t stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign head_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_lsu_bridge.sv
// Pipelined req/gnt/rvalid bridge to a single-port SRAM with fixed read latency,
// out-of-range error responses and first-error address capture.
module sram_lsu_bridge
  import sram_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int RD_LATENCY = 1,
  localparam int BW        = DATA_WIDTH / 8,
  localparam int IW        = $clog2(MEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic                  data_we_i,
  input  logic [BW-1:0]         data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  input  logic                  mem_ready_i,
  output logic                  CE,
  output logic                  WE,
  output logic [BW-1:0]         BE,
  output logic [IW-1:0]         A,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  input  logic                  err_clr_i
);

  localparam int OFFS = $clog2(BW);

  if (!params_legal(DATA_WIDTH, ADDR_WIDTH, MEM_WORDS, RD_LATENCY)) begin : g_bad_params
    $error("sram_lsu_bridge: illegal parameter combination");
  end

  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_range;
  logic                  sram_sel;
  logic                  err_grant;
  resp_entry_t           push_entry;
  resp_entry_t           head_entry;
  err_state_e            err_state_q;

  assign widx       = data_addr_i >> OFFS;
  assign in_range   = (widx < ADDR_WIDTH'(MEM_WORDS));
  assign data_gnt_o = data_req_i & mem_ready_i;
  assign sram_sel   = data_gnt_o & in_range;
  assign err_grant  = data_gnt_o & ~in_range;

  // SRAM strobes are held at zero whenever the macro is not selected.
  assign CE = sram_sel;
  assign WE = sram_sel & data_we_i;
  assign BE = sram_sel ? data_be_i : '0;
  assign A  = sram_sel ? widx[IW-1:0] : '0;
  assign D  = sram_sel ? data_wdata_i : '0;

  assign push_entry.valid = data_gnt_o;
  assign push_entry.we    = data_gnt_o & data_we_i;
  assign push_entry.err   = err_grant;

  sram_lsu_resp_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_entry),
    .head_o (head_entry)
  );

  assign data_rvalid_o = head_entry.valid;
  assign data_err_o    = head_entry.valid & head_entry.err;
  assign data_rdata_o  = (head_entry.valid && !head_entry.we && !head_entry.err) ? Q : '0;

  // A clear coinciding with a new error re-arms and captures in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_state_q <= ERR_ARMED;
      err_addr_o  <= '0;
    end else begin
      case (err_state_q)
        ERR_ARMED: begin
          if (err_grant) begin
            err_state_q <= ERR_HELD;
            err_addr_o  <= data_addr_i;
          end
        end
        ERR_HELD: begin
          if (err_clr_i && err_grant) begin
            err_addr_o <= data_addr_i;
          end else if (err_clr_i) begin
            err_state_q <= ERR_ARMED;
            err_addr_o  <= '0;
          end
        end
        default: begin
          err_state_q <= ERR_ARMED;
          err_addr_o  <= '0;
        end
      endcase
    end
  end

  assign err_valid_o = (err_state_q == ERR_HELD);

endmodule

// File: tb/tb_sram_lsu_bridge.sv
// Directed bench for sram_lsu_bridge with a behavioural SRAM and an in-order response scoreboard.
module tb_sram_lsu_bridge;

  localparam int DW  = 32;
  localparam int AWB = 32;
  localparam int MW  = 1024;
  localparam int LAT = 2;
  localparam int BW  = DW / 8;
  localparam int IW  = $clog2(MW);

  logic           clk;
  logic           rst_ni;
  logic           data_req_i;
  logic           data_gnt_o;
  logic           data_we_i;
  logic [BW-1:0]  data_be_i;
  logic [AWB-1:0] data_addr_i;
  logic [DW-1:0]  data_wdata_i;
  logic           data_rvalid_o;
  logic [DW-1:0]  data_rdata_o;
  logic           data_err_o;
  logic           mem_ready_i;
  logic           CE;
  logic           WE;
  logic [BW-1:0]  BE;
  logic [IW-1:0]  A;
  logic [DW-1:0]  D;
  logic [DW-1:0]  Q;
  logic           err_valid_o;
  logic [AWB-1:0] err_addr_o;
  logic           err_clr_i;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] ref_mem [MW];

  sram_lsu_bridge #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AWB),
    .MEM_WORDS  (MW),
    .RD_LATENCY (LAT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .mem_ready_i   (mem_ready_i),
    .CE            (CE),
    .WE            (WE),
    .BE            (BE),
    .A             (A),
    .D             (D),
    .Q             (Q),
    .err_valid_o   (err_valid_o),
    .err_addr_o    (err_addr_o),
    .err_clr_i     (err_clr_i)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: Q appears LAT cycles after a read CE, garbage otherwise
  logic [DW-1:0] sram [MW];
  logic [DW-1:0] rd_pipe [LAT];
  bit            loaded;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < MW; i++) sram[i] = '0;
      for (int i = 0; i < 4; i++) sram[i] = DW'(i + 1);
      loaded = 1'b1;
    end
    rd_pipe[0] <= (CE && !WE) ? sram[A] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (CE && WE) begin
      for (int b = 0; b < BW; b++) if (BE[b]) sram[A][8*b +: 8] = D[8*b +: 8];
    end
  end
  assign Q = rd_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every rvalid pops the oldest expected {err, rdata}
  always @(negedge clk) begin
    if (rst_ni && data_rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 64'(data_rvalid_o), 64'(0));
      end else begin
        check("resp", 64'({data_err_o, data_rdata_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_addr_i  = '0;
    data_wdata_i = '0;
  endtask

  task automatic expect_resp(input logic we, input logic [AWB-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    logic [AWB-1:0] w;
    w = addr >> 2;
    if (w >= AWB'(MW)) begin
      exp_q.push_back({1'b1, 32'h0});
    end else if (we) begin
      for (int b = 0; b < BW; b++) if (be[b]) ref_mem[w[IW-1:0]][8*b +: 8] = wdata[8*b +: 8];
      exp_q.push_back({1'b0, 32'h0});
    end else begin
      exp_q.push_back({1'b0, ref_mem[w[IW-1:0]]});
    end
  endtask

  task automatic drive(input logic we, input logic [AWB-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    data_be_i    = be;
  endtask

  task automatic issue(input logic we, input logic [AWB-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    drive(we, addr, wdata, be);
    expect_resp(we, addr, wdata, be);
  endtask

  initial begin
    for (int i = 0; i < MW; i++) ref_mem[i] = '0;
    for (int i = 0; i < 4; i++) ref_mem[i] = DW'(i + 1);
    rst_ni      = 1'b0;
    mem_ready_i = 1'b1;
    err_clr_i   = 1'b0;
    idle();
    step();
    step();
    #1;
    check("rst_rvalid", 64'(data_rvalid_o), 64'(0));
    check("rst_rdata", 64'(data_rdata_o), 64'(0));
    check("rst_err", 64'(data_err_o), 64'(0));
    check("rst_err_valid", 64'(err_valid_o), 64'(0));
    check("rst_err_addr", 64'(err_addr_o), 64'(0));
    check("rst_ce", 64'(CE), 64'(0));
    rst_ni = 1'b1;
    step();

    // Write 0x10 then read it back with exact latency checks
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    #1;
    check("s1_gnt", 64'(data_gnt_o), 64'(1));
    check("s1_ce", 64'(CE), 64'(1));
    check("s1_we", 64'(WE), 64'(1));
    check("s1_a", 64'(A), 64'(4));
    check("s1_d", 64'(D), 64'(32'hDEAD_BEEF));
    check("s1_be", 64'(BE), 64'(4'hF));
    step();
    idle();
    #1;
    check("s1_idle_ce", 64'(CE), 64'(0));
    check("s1_idle_a", 64'(A), 64'(0));
    check("s1_t1_rvalid", 64'(data_rvalid_o), 64'(0));
    step();
    #1;
    check("s1_t2_rvalid", 64'(data_rvalid_o), 64'(1));
    check("s1_t2_err", 64'(data_err_o), 64'(0));

    issue(1'b0, 32'h10, 32'h0, 4'hF);
    #1;
    check("s2_ce", 64'(CE), 64'(1));
    check("s2_we", 64'(WE), 64'(0));
    step();
    idle();
    #1;
    check("s2_t1_rvalid", 64'(data_rvalid_o), 64'(0));
    step();
    #1;
    check("s2_t2_rvalid", 64'(data_rvalid_o), 64'(1));
    check("s2_t2_rdata", 64'(data_rdata_o), 64'(32'hDEAD_BEEF));
    step();
    #1;
    check("s2_t3_rvalid", 64'(data_rvalid_o), 64'(0));

    // Back-to-back reads of the preloaded words
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, AWB'(4 * i), 32'h0, 4'hF);
      step();
    end
    idle();
    #1;
    check("s3_first_rvalid", 64'(data_rvalid_o), 64'(1));
    step();
    step();
    step();

    // Partial write, readback, and top-of-memory boundary read
    issue(1'b1, 32'h14, 32'hAABB_CCDD, 4'h3);
    step();
    issue(1'b0, 32'h14, 32'h0, 4'hF);
    step();
    issue(1'b0, 32'hFFC, 32'h0, 4'hF);
    #1;
    check("edge_ce", 64'(CE), 64'(1));
    check("edge_a", 64'(A), 64'(1023));
    step();
    idle();
    step();
    step();

    // Stall on mem_ready_i with a response draining underneath it
    issue(1'b0, 32'h0, 32'h0, 4'hF);
    step();
    mem_ready_i = 1'b0;
    drive(1'b0, 32'h4, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s4_stall_gnt", 64'(data_gnt_o), 64'(0));
      check("s4_stall_ce", 64'(CE), 64'(0));
      step();
    end
    mem_ready_i = 1'b1;
    expect_resp(1'b0, 32'h4, 32'h0, 4'hF);
    #1;
    check("s4_gnt", 64'(data_gnt_o), 64'(1));
    step();
    idle();
    #1;
    check("s4_t1_rvalid", 64'(data_rvalid_o), 64'(0));
    step();
    #1;
    check("s4_t2_rvalid", 64'(data_rvalid_o), 64'(1));
    check("s4_t2_rdata", 64'(data_rdata_o), 64'(2));
    step();

    // Out-of-range reads and first-error capture
    issue(1'b0, 32'h1000, 32'h0, 4'hF);
    #1;
    check("s5_gnt", 64'(data_gnt_o), 64'(1));
    check("s5_ce0", 64'(CE), 64'(0));
    step();
    issue(1'b0, 32'h2000, 32'h0, 4'hF);
    #1;
    check("s5_ce1", 64'(CE), 64'(0));
    step();
    idle();
    #1;
    check("s5_err_rdata", 64'(data_rdata_o), 64'(0));
    check("s5_err_flag", 64'(data_err_o), 64'(1));
    step();
    check("s5_err_valid", 64'(err_valid_o), 64'(1));
    check("s5_err_addr", 64'(err_addr_o), 64'(32'h1000));
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    #1;
    check("s5_clr_valid", 64'(err_valid_o), 64'(0));
    check("s5_clr_addr", 64'(err_addr_o), 64'(0));
    issue(1'b1, 32'h3000, 32'h1234_5678, 4'hF);
    #1;
    check("s5_wr_oor_we", 64'(WE), 64'(0));
    step();
    issue(1'b0, 32'h4000, 32'h0, 4'hF);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    idle();
    #1;
    check("s5_same_cycle_valid", 64'(err_valid_o), 64'(1));
    check("s5_same_cycle_addr", 64'(err_addr_o), 64'(32'h4000));
    step();
    step();

    // Reset with two reads in flight
    issue(1'b0, 32'h0, 32'h0, 4'hF);
    step();
    issue(1'b0, 32'h4, 32'h0, 4'hF);
    step();
    rst_ni = 1'b0;
    idle();
    exp_q.delete();
    #1;
    check("s6_async_rvalid", 64'(data_rvalid_o), 64'(0));
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("s6_rvalid", 64'(data_rvalid_o), 64'(0));
      check("s6_outs", 64'({data_rdata_o, data_err_o, err_valid_o, err_addr_o}), 64'(0));
    end

    // Bounded drain of anything still expected
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    check("drain", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sram_lsu_bridge.md
# sram_lsu_bridge

Pipelined bridge between the core data port (req/gnt/rvalid protocol) and a synchronous single-port SRAM macro with configurable read latency. One request is accepted per cycle; responses return in order after exactly `RD_LATENCY` cycles. Out-of-range accesses are answered with an error response without touching the SRAM. The first error address is captured for software. It replaces the single-cycle, one-outstanding core memory adapter in the subsystem's data path.

## Interface
- `DATA_WIDTH`, 32: data bus width; multiple of 8.
- `ADDR_WIDTH`, 32: core byte-address width.
- `MEM_WORDS`, 1024: SRAM depth in words; power of two, at least 2.
- `RD_LATENCY`, 1: cycles from the `CE` cycle to valid `Q`; legal range 1..4.
- `clk_i` in 1: single clock; all state is rising-edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `data_req_i` in 1: core request.
- `data_gnt_o` out 1: request accepted this cycle.
- `data_we_i` in 1: 1 = write, 0 = read.
- `data_be_i` in DATA_WIDTH/8: byte enables.
- `data_addr_i` in ADDR_WIDTH: byte address.
- `data_wdata_i` in DATA_WIDTH: write data.
- `data_rvalid_o` out 1: response valid.
- `data_rdata_o` out DATA_WIDTH: read data.
- `data_err_o` out 1: response is an error; qualified by `data_rvalid_o`.
- `mem_ready_i` in 1: SRAM port available; 0 = arbiter holds it.
- `CE` out 1: SRAM chip enable.
- `WE` out 1: SRAM write enable.
- `BE` out DATA_WIDTH/8: SRAM byte enables.
- `A` out $clog2(MEM_WORDS): SRAM word address.
- `D` out DATA_WIDTH: SRAM write data.
- `Q` in DATA_WIDTH: SRAM read data.
- `err_valid_o` out 1: sticky error-capture flag.
- `err_addr_o` out ADDR_WIDTH: byte address of the first error.
- `err_clr_i` in 1: clears the capture and re-arms it.

## Operation
- **Grant:** `data_gnt_o = data_req_i & mem_ready_i`, combinational, with no stall from in-flight responses. Core request fields are sampled only in the grant cycle.
- **Word index and range check:** `widx = data_addr_i >> $clog2(DATA_WIDTH/8)`. The access is in range when `widx < MEM_WORDS`.
- **In-range grant:**
  - `CE = 1` in the grant cycle, with `WE = data_we_i`, `BE = data_be_i`, `A = widx` truncated, and `D = data_wdata_i`.
  - `CE`, `WE`, `BE`, `A` and `D` are combinational from the core inputs.
- **Out-of-range grant:** `CE = 0` and `WE = 0`. An entry with `err = 1` is pushed into the response pipeline.
- **Idle drive:** whenever `CE = 0`, `WE`, `BE`, `A` and `D` are driven to 0.
- **Response pipeline:** a shift register `RD_LATENCY` deep holding {valid, we, err}. Each grant pushes one entry; the output stage drives `data_rvalid_o` and `data_err_o`.
- **Response data:** `data_rdata_o = Q` when the output entry is a valid read with no error; otherwise 0.
- **Write responses:** writes also produce a response (rvalid, err = 0) after `RD_LATENCY` cycles.
- **Error capture:** a two-state machine (ARMED, HELD).
  - ARMED: an out-of-range grant loads `err_addr_o` and moves to HELD (`err_valid_o = 1`).
  - HELD: later errors are ignored.
  - `err_clr_i` returns to ARMED and zeroes `err_addr_o`.
  - If `err_clr_i` and an error grant occur in the same cycle, the new error is captured and the state stays HELD.

## Timing
- **Reset values:** every registered output is 0; `data_rvalid_o`, `data_err_o` and `data_rdata_o` are 0 while the pipeline is empty; the capture state is ARMED.
- **Latency:** grant in cycle T gives the response in cycle T+`RD_LATENCY`. Throughput is one access per cycle, with at most `RD_LATENCY` responses in flight.
- **Ordering:** responses are strictly in grant order, including errors interleaved with SRAM accesses.
- **No backpressure:** the core always accepts rvalid.
- **`mem_ready_i` low:** no grant and `CE = 0`. The pipeline keeps draining; a response can coincide with a stalled request.
- **Reset mid-operation:** all in-flight entries are discarded and no response is issued after reset release. SRAM contents are not affected by the bridge.

## Structure
- Package `sram_lsu_pkg`:
  - `resp_entry_t` struct (valid, we, err).
  - `RD_LATENCY_MAX = 4`.
  - Parameter-legality checks as elaboration assertions.
- Sub-module `sram_lsu_resp_pipe`: a parametrised shift register of `resp_entry_t`, depth `RD_LATENCY`, with asynchronous clear.

## Test plan
All scenarios use `DATA_WIDTH` = 32, `MEM_WORDS` = 1024, `RD_LATENCY` = 2.
1. Write to 0x10, wdata 0xDEADBEEF, be 0xF -> in the same cycle `gnt = 1`, `CE = 1`, `WE = 1`, `A = 4`, `D` = 0xDEADBEEF; rvalid = 1 and err = 0 at T+2.
2. Read 0x10 after scenario 1 -> rvalid at T+2 with rdata 0xDEADBEEF; rvalid = 0 at T+1 and T+3.
3. Reads of 0x0, 0x4, 0x8, 0xC on consecutive cycles (SRAM preloaded 1..4) -> four consecutive rvalids carrying 1, 2, 3, 4.
4. Request held with `mem_ready_i = 0` for 3 cycles -> `gnt = 0` and `CE = 0`. `mem_ready_i` rises -> gnt is issued in that same cycle and the response arrives 2 cycles later.
5. Read 0x1000, then 0x2000 -> `CE = 0` for both; two rvalids with err = 1 and rdata = 0. `err_valid_o = 1` and `err_addr_o` = 0x1000 (not overwritten). `err_clr_i` pulse -> both cleared.
6. `rst_ni` asserted with 2 reads in flight, released 1 cycle later -> no rvalid for 5 cycles and all outputs 0.
